hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline interlock and forwarding controller for the decode→execute boundary of the RISC CPU. It tracks the destinations of the two instructions in flight beyond decode (execute and memory stages). From that it generates:
- load-use stalls
- bubble insertion into the decode/execute delay register
- multi-cycle multiply sequencing
- branch flush
- registered forwarding selects aligned with the execute stage

It sits beside the decode/execute delay register and drives its hold/bubble behaviour.

## Interface
Parameters:
- OP_LOAD, 6'b000011, opcode of load instructions
- OP_MUL, 6'b000100, opcode of multiply instructions
- MUL_LAT, 4, multiply execute latency in cycles (legal range 2..15)

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high reset
- opcode  in  6  opcode of instruction in decode
- rs1, rs2  in  5 each  source register indices in decode
- rd  in  5  destination index in decode
- register_we  in  1  decode instruction writes rd
- branch_taken  in  1  execute-stage branch resolved taken
- stall  out  1  hold PC and decode this cycle (combinational)
- bubble  out  1  delay register loads register_we/data_we = 0 this cycle (combinational)
- ex_hold  out  1  delay register keeps its contents this cycle (combinational)
- flush  out  1  squash fetch/decode (combinational, equals branch_taken)
- mul_busy  out  1  multiply FSM in BUSY (registered)
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  registered select for the execute-stage operand: 0 = register file, 1 = memory-stage result, 2 = writeback value

## Operation
- Shadow pipeline holds two slots:
  - E: valid, rd, we, is_load
  - M: valid, rd, we
- A slot "writes r" iff valid && we && rd == r && r != 0.
- Index 0 never hazards or forwards.
- issue = !stall && !flush && !mul_busy.
- load_use = E.is_load && (E writes rs1 || E writes rs2).
- Combinational output priority:
  1. flush: stall = 0, bubble = 1, flush = 1.
  2. else mul_busy: stall = 1, ex_hold = 1, bubble = 0.
  3. else load_use: stall = 1, bubble = 1.
  4. else: all deasserted.
- Update on each clock edge when reset is low:
  - If ex_hold: E is unchanged and M ← invalid.
  - Otherwise M ← E, and E ← the decode instruction if issue, else invalid. The captured decode instruction has we = register_we and is_load = (opcode == OP_LOAD).
- Forwarding selects are registered, and update only when ex_hold = 0.
  - On issue, each select is computed against the pre-edge slots: 1 if E writes rsX, else 2 if M writes rsX, else 0.
  - When no instruction issues, both selects load 0.
- Multiply FSM, states IDLE and BUSY:
  - IDLE→BUSY on an issue with opcode == OP_MUL; cnt ← MUL_LAT−1.
  - In BUSY, cnt decrements each cycle; BUSY→IDLE when cnt == 1 at the edge.
  - mul_busy is high for exactly MUL_LAT−1 cycles.
- A MUL that is stalled or flushed in decode does not start the FSM.
- branch_taken asserted during BUSY is illegal; the bench flags it and the design ignores it.
- Reset (any cycle, including mid-BUSY):
  - FSM → IDLE, cnt = 0.
  - E and M invalid.
  - fwd selects = 0, mul_busy = 0.
  - The combinational outputs then evaluate to 0 unless branch_taken is high.

## Timing
- Forwarding latency: selects are valid in the cycle the instruction occupies execute, i.e. one cycle after issue, together with the delay register outputs.
- Load-use costs exactly one bubble: the next cycle the load is in M, load_use is clear, and the consumer issues with sel = 2.
- A MUL issued at cycle t:
  - Stall is high t+1 .. t+MUL_LAT−1.
  - The next instruction issues at t+MUL_LAT and forwards from the MUL with sel = 1.
- Back-to-back MUL: the second issues at t+MUL_LAT and re-enters BUSY at t+MUL_LAT+1.
- Flush and load_use in the same cycle: flush wins, no stall, the decode slot is squashed.

## Test plan
- Reset for 2 cycles, then idle → stall = bubble = ex_hold = mul_busy = 0, fwd selects = 0.
- ADD r3 then SUB rs1 = r3 back-to-back → no stall; SUB's fwd_rs1_sel = 1 in its execute cycle.
- LOAD r5 then ADD rs2 = r5 → one cycle of stall = bubble = 1; ADD issues next cycle with fwd_rs2_sel = 2.
- MUL r7 (MUL_LAT = 4) then ADD rs1 = r7 → mul_busy and stall high for 3 cycles, ex_hold high for 3; ADD issues with fwd_rs1_sel = 1; a second MUL directly after re-enters BUSY.
- LOAD r0 then ADD rs1 = r0, and a write to r4 with register_we = 0 → no stall, selects 0.
- branch_taken while decode holds a load-use consumer → flush = 1, bubble = 1, stall = 0. Separately, reset mid-BUSY → mul_busy = 0 on the next cycle and decode issues immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode/execute interlock: tracks the EX and MEM destinations, raises load-use and
// multiply stalls, squashes on taken branches and registers operand forwarding selects.
module hazard_ctrl #(
    parameter logic [5:0] OP_LOAD = 6'b000011,
    parameter logic [5:0] OP_MUL  = 6'b000100,
    parameter int         MUL_LAT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       register_we,
    input  logic       branch_taken,
    output logic       stall,
    output logic       bubble,
    output logic       ex_hold,
    output logic       flush,
    output logic       mul_busy,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel
);

    typedef enum logic {IDLE, BUSY} mul_st_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    mul_st_t    st_q;
    logic [3:0] cnt_q;
    logic       mul_busy_q;

    logic       e_vld_q, e_we_q, e_ld_q;
    logic [4:0] e_rd_q;
    logic       m_vld_q, m_we_q;
    logic [4:0] m_rd_q;
    logic [1:0] fwd1_q, fwd1_d;
    logic [1:0] fwd2_q, fwd2_d;

    logic e_wr_rs1, e_wr_rs2, m_wr_rs1, m_wr_rs2;
    logic load_use, issue;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign e_wr_rs1 = e_vld_q && e_we_q && (e_rd_q == rs1) && (rs1 != 5'd0);
    assign e_wr_rs2 = e_vld_q && e_we_q && (e_rd_q == rs2) && (rs2 != 5'd0);
    assign m_wr_rs1 = m_vld_q && m_we_q && (m_rd_q == rs1) && (rs1 != 5'd0);
    assign m_wr_rs2 = m_vld_q && m_we_q && (m_rd_q == rs2) && (rs2 != 5'd0);

    assign load_use = e_ld_q && (e_wr_rs1 || e_wr_rs2);
    assign flush    = branch_taken;
    assign mul_busy = mul_busy_q;

    always_comb begin
        stall   = 1'b0;
        bubble  = 1'b0;
        ex_hold = 1'b0;
        if (branch_taken) begin
            bubble = 1'b1;
        end else if (mul_busy_q) begin
            stall   = 1'b1;
            ex_hold = 1'b1;
        end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
    end

    assign issue = !stall && !flush && !mul_busy_q;

    always_comb begin
        fwd1_d = 2'd0;
        fwd2_d = 2'd0;
        if (issue) begin
            fwd1_d = e_wr_rs1 ? 2'd1 : (m_wr_rs1 ? 2'd2 : 2'd0);
            fwd2_d = e_wr_rs2 ? 2'd1 : (m_wr_rs2 ? 2'd2 : 2'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q       <= IDLE;
            cnt_q      <= 4'd0;
            mul_busy_q <= 1'b0;
            e_vld_q    <= 1'b0;
            e_we_q     <= 1'b0;
            e_ld_q     <= 1'b0;
            e_rd_q     <= 5'd0;
            m_vld_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_rd_q     <= 5'd0;
            fwd1_q     <= 2'd0;
            fwd2_q     <= 2'd0;
        end else begin
            // While the multiply occupies execute it stays put; MEM drains to empty.
            if (ex_hold) begin
                m_vld_q <= 1'b0;
            end else begin
                m_vld_q <= e_vld_q;
                m_we_q  <= e_we_q;
                m_rd_q  <= e_rd_q;
                e_vld_q <= issue;
                e_we_q  <= register_we;
                e_ld_q  <= issue && (opcode == OP_LOAD);
                e_rd_q  <= rd;
                fwd1_q  <= fwd1_d;
                fwd2_q  <= fwd2_d;
            end

            case (st_q)
                IDLE: begin
                    if (issue && (opcode == OP_MUL)) begin
                        st_q       <= BUSY;
                        cnt_q      <= CNT_INIT;
                        mul_busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        st_q       <= IDLE;
                        mul_busy_q <= 1'b0;
                    end
                end
                default: begin
                    st_q       <= IDLE;
                    mul_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign fwd_rs1_sel = fwd1_q;
    assign fwd_rs2_sel = fwd2_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-stamped reference model checked every
// negedge, plus literal expectations for each scenario.
module tb_hazard_ctrl;

    localparam int         MUL_LAT = 4;
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_LOAD = 6'b000011;
    localparam logic [5:0] OP_MUL  = 6'b000100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       register_we = 1'b0;
    logic       branch_taken = 1'b0;
    logic       stall, bubble, ex_hold, flush, mul_busy;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    always #5 clock = ~clock;

    hazard_ctrl #(.OP_LOAD(OP_LOAD), .OP_MUL(OP_MUL), .MUL_LAT(MUL_LAT)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .register_we(register_we), .branch_taken(branch_taken),
        .stall(stall), .bubble(bubble), .ex_hold(ex_hold), .flush(flush),
        .mul_busy(mul_busy), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: two in-flight slots plus the cycle stamp of the last MUL issue.
    bit         ex_v, ex_we, ex_ld, mm_v, mm_we;
    logic [4:0] ex_rd, mm_rd;
    logic [1:0] s1_exp, s2_exp;
    int         cyc   = 0;
    int         mul_t = -1;

    function automatic bit ex_writes(logic [4:0] r);
        return ex_v && ex_we && (ex_rd == r) && (r != 5'd0);
    endfunction

    function automatic bit mm_writes(logic [4:0] r);
        return mm_v && mm_we && (mm_rd == r) && (r != 5'd0);
    endfunction

    function automatic bit model_busy();
        return (mul_t >= 0) && (cyc > mul_t) && (cyc < mul_t + MUL_LAT);
    endfunction

    function automatic logic [1:0] src_of(logic [4:0] r);
        if (ex_writes(r)) return 2'd1;
        if (mm_writes(r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            ex_v = 0; ex_we = 0; ex_ld = 0; ex_rd = '0;
            mm_v = 0; mm_we = 0; mm_rd = '0;
            s1_exp = 2'd0; s2_exp = 2'd0;
            mul_t = -1;
        end else begin
            bit busy, lu, issue;
            busy  = model_busy();
            lu    = ex_v && ex_ld && (ex_writes(rs1) || ex_writes(rs2));
            issue = !branch_taken && !busy && !lu;
            if (!branch_taken && busy) begin
                mm_v = 0;
            end else begin
                s1_exp = issue ? src_of(rs1) : 2'd0;
                s2_exp = issue ? src_of(rs2) : 2'd0;
                mm_v = ex_v; mm_we = ex_we; mm_rd = ex_rd;
                ex_v = issue; ex_we = register_we; ex_rd = rd;
                ex_ld = (opcode == OP_LOAD);
            end
            if (issue && opcode == OP_MUL) mul_t = cyc;
        end
        cyc++;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit busy, lu;
            logic e_stall, e_bub, e_hold;
            busy = model_busy();
            lu   = ex_v && ex_ld && (ex_writes(rs1) || ex_writes(rs2));
            e_stall = 0; e_bub = 0; e_hold = 0;
            if (branch_taken) e_bub = 1;
            else if (busy) begin e_stall = 1; e_hold = 1; end
            else if (lu) begin e_stall = 1; e_bub = 1; end
            check("m_stall", {7'd0, stall}, {7'd0, e_stall});
            check("m_bubble", {7'd0, bubble}, {7'd0, e_bub});
            check("m_ex_hold", {7'd0, ex_hold}, {7'd0, e_hold});
            check("m_flush", {7'd0, flush}, {7'd0, branch_taken});
            check("m_mul_busy", {7'd0, mul_busy}, {7'd0, busy});
            check("m_fwd1", {6'd0, fwd_rs1_sel}, {6'd0, s1_exp});
            check("m_fwd2", {6'd0, fwd_rs2_sel}, {6'd0, s2_exp});
            if (branch_taken && busy) begin
                n_fail++;
                $display("FAIL illegal_branch_in_busy at t=%0t: got branch_taken=1, expected 0", $time);
            end
        end
    end

    // Present one decode instruction for a cycle; returns shortly before the next negedge.
    task automatic cyc_in(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic we, input logic br, input logic rst);
        @(posedge clock);
        #1;
        opcode = op; rs1 = a; rs2 = b; rd = d; register_we = we; branch_taken = br; reset = rst;
        #3;
    endtask

    task automatic nop();
        cyc_in(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clock);
        chk_en = 1'b1;
        // reset held two cycles, then idle
        cyc_in(OP_NOP, 0, 0, 0, 0, 0, 1);
        nop();
        check("rst_stall", {7'd0, stall}, 8'd0);
        check("rst_bubble", {7'd0, bubble}, 8'd0);
        check("rst_ex_hold", {7'd0, ex_hold}, 8'd0);
        check("rst_mul_busy", {7'd0, mul_busy}, 8'd0);
        check("rst_fwd1", {6'd0, fwd_rs1_sel}, 8'd0);
        check("rst_fwd2", {6'd0, fwd_rs2_sel}, 8'd0);

        // ADD r3 then SUB r3: EX forward
        cyc_in(OP_ADD, 1, 2, 3, 1, 0, 0);
        check("add_stall", {7'd0, stall}, 8'd0);
        cyc_in(OP_SUB, 3, 1, 8, 1, 0, 0);
        check("sub_stall", {7'd0, stall}, 8'd0);
        nop();
        check("sub_fwd1", {6'd0, fwd_rs1_sel}, 8'd1);
        check("sub_fwd2", {6'd0, fwd_rs2_sel}, 8'd0);

        // LOAD r5 then ADD rs2=r5: one bubble, then MEM forward
        cyc_in(OP_LOAD, 1, 0, 5, 1, 0, 0);
        check("ld_stall", {7'd0, stall}, 8'd0);
        cyc_in(OP_ADD, 2, 5, 9, 1, 0, 0);
        check("lu_stall", {7'd0, stall}, 8'd1);
        check("lu_bubble", {7'd0, bubble}, 8'd1);
        check("lu_hold", {7'd0, ex_hold}, 8'd0);
        cyc_in(OP_ADD, 2, 5, 9, 1, 0, 0);
        check("lu_retry_stall", {7'd0, stall}, 8'd0);
        nop();
        check("lu_fwd2", {6'd0, fwd_rs2_sel}, 8'd2);
        check("lu_fwd1", {6'd0, fwd_rs1_sel}, 8'd0);

        // MUL r7, dependent ADD waits MUL_LAT-1 cycles, then back-to-back MUL
        cyc_in(OP_MUL, 1, 2, 7, 1, 0, 0);
        check("mul_issue_stall", {7'd0, stall}, 8'd0);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            cyc_in(OP_ADD, 7, 0, 11, 1, 0, 0);
            check("mul_busy_on", {7'd0, mul_busy}, 8'd1);
            check("mul_stall_on", {7'd0, stall}, 8'd1);
            check("mul_hold_on", {7'd0, ex_hold}, 8'd1);
            check("mul_no_bubble", {7'd0, bubble}, 8'd0);
        end
        cyc_in(OP_ADD, 7, 0, 11, 1, 0, 0);
        check("mul_done_busy", {7'd0, mul_busy}, 8'd0);
        check("mul_done_stall", {7'd0, stall}, 8'd0);
        cyc_in(OP_MUL, 1, 1, 10, 1, 0, 0);
        check("mul_fwd1", {6'd0, fwd_rs1_sel}, 8'd1);
        check("mul2_issue_stall", {7'd0, stall}, 8'd0);
        nop();
        check("mul2_busy", {7'd0, mul_busy}, 8'd1);
        repeat (MUL_LAT - 1) nop();
        check("mul2_done", {7'd0, mul_busy}, 8'd0);

        // r0 never hazards; we=0 writer never forwards
        cyc_in(OP_LOAD, 1, 0, 0, 1, 0, 0);
        cyc_in(OP_ADD, 0, 0, 12, 1, 0, 0);
        check("r0_stall", {7'd0, stall}, 8'd0);
        cyc_in(OP_ADD, 1, 1, 4, 0, 0, 0);
        check("r0_fwd1", {6'd0, fwd_rs1_sel}, 8'd0);
        cyc_in(OP_ADD, 4, 4, 13, 1, 0, 0);
        check("nowe_stall", {7'd0, stall}, 8'd0);
        nop();
        check("nowe_fwd1", {6'd0, fwd_rs1_sel}, 8'd0);
        check("nowe_fwd2", {6'd0, fwd_rs2_sel}, 8'd0);

        // flush beats load-use
        cyc_in(OP_LOAD, 1, 0, 6, 1, 0, 0);
        cyc_in(OP_ADD, 6, 0, 14, 1, 1, 0);
        check("fl_flush", {7'd0, flush}, 8'd1);
        check("fl_bubble", {7'd0, bubble}, 8'd1);
        check("fl_stall", {7'd0, stall}, 8'd0);
        check("fl_hold", {7'd0, ex_hold}, 8'd0);
        nop();
        check("fl_after_stall", {7'd0, stall}, 8'd0);

        // reset while multiply is busy
        cyc_in(OP_MUL, 1, 2, 7, 1, 0, 0);
        cyc_in(OP_NOP, 0, 0, 0, 0, 0, 1);
        check("rb_busy_before", {7'd0, mul_busy}, 8'd1);
        cyc_in(OP_ADD, 7, 0, 15, 1, 0, 0);
        check("rb_busy_cleared", {7'd0, mul_busy}, 8'd0);
        check("rb_stall", {7'd0, stall}, 8'd0);
        check("rb_fwd1", {6'd0, fwd_rs1_sel}, 8'd0);
        nop();
        check("rb_issue_fwd1", {6'd0, fwd_rs1_sel}, 8'd0);
        check("rb_issue_stall", {7'd0, stall}, 8'd0);
        repeat (3) nop();

        @(posedge clock);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
